// File: rtl/fat32_dir_scanner.sv
// Streaming FAT32 directory-entry matcher: splits sector bytes into 32-byte entries
// and compares each live entry against a latched 8.3 target name, with no sector buffer.
module fat32_dir_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] filename,
    input  logic [23:0] extension,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        block_done,
    output logic        busy,
    output logic        found,
    output logic        end_of_dir,
    output logic        sector_done,
    output logic [31:0] first_cluster,
    output logic [31:0] file_size,
    output logic [3:0]  entry_slot
);
    typedef enum logic [1:0] {IDLE, SCAN, FOUND, END} state_t;

    state_t           state, state_next;
    logic [10:0][7:0] target;     // [10] is the first filename character
    logic [8:0]       cnt;
    logic             match;
    logic [15:0]      cl_hi, cl_lo;
    logic [23:0]      size_lo;

    logic [4:0] offset;
    logic       byte_live, hit_end, hit_found, byte_ok, match_next;

    assign offset    = cnt[4:0];
    assign byte_live = (state == SCAN) && byte_valid && !start;
    assign hit_end   = byte_live && (offset == 5'd0) && (byte_in == 8'h00);
    assign hit_found = byte_live && (offset == 5'd31) && match;

    assign busy       = (state == SCAN);
    assign found      = (state == FOUND);
    assign end_of_dir = (state == END);

    // Per-byte verdict; deleted, LFN, volume-label and directory entries never match
    always_comb begin
        byte_ok = 1'b1;
        if (offset <= 5'd10)
            byte_ok = (byte_in == target[4'd10 - offset[3:0]]);
        if (offset == 5'd0 && byte_in == 8'hE5)
            byte_ok = 1'b0;
        if (offset == 5'd11 && (byte_in == 8'h0F || byte_in[3] || byte_in[4]))
            byte_ok = 1'b0;
        match_next = ((offset == 5'd0) ? 1'b1 : match) && byte_ok;
    end

    always_comb begin
        state_next = state;
        if (start)
            state_next = SCAN;
        else if (hit_end)
            state_next = END;
        else if (hit_found)
            state_next = FOUND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target        <= '0;
            cnt           <= '0;
            match         <= 1'b0;
            cl_hi         <= '0;
            cl_lo         <= '0;
            size_lo       <= '0;
            first_cluster <= '0;
            file_size     <= '0;
            entry_slot    <= '0;
            sector_done   <= 1'b0;
        end else if (start) begin
            target        <= {filename, extension};
            cnt           <= '0;
            match         <= 1'b0;
            cl_hi         <= '0;
            cl_lo         <= '0;
            size_lo       <= '0;
            first_cluster <= '0;
            file_size     <= '0;
            entry_slot    <= '0;
            sector_done   <= 1'b0;
        end else begin
            sector_done <= 1'b0;
            if (state == SCAN) begin
                if (byte_valid) begin
                    match <= match_next;
                    cnt   <= cnt + 9'd1;
                    case (offset)
                        5'd20: cl_hi[7:0]      <= byte_in;
                        5'd21: cl_hi[15:8]     <= byte_in;
                        5'd26: cl_lo[7:0]      <= byte_in;
                        5'd27: cl_lo[15:8]     <= byte_in;
                        5'd28: size_lo[7:0]    <= byte_in;
                        5'd29: size_lo[15:8]   <= byte_in;
                        5'd30: size_lo[23:16]  <= byte_in;
                        default: ;
                    endcase
                    // Last size byte is still on the bus, not yet in the shadow
                    if (hit_found) begin
                        first_cluster <= {4'h0, cl_hi[11:0], cl_lo};
                        file_size     <= {byte_in, size_lo};
                        entry_slot    <= cnt[8:5];
                    end
                end
                // A byte arriving with block_done is consumed before the sector closes
                if (block_done) begin
                    cnt         <= '0;
                    sector_done <= !hit_found && !hit_end;
                end
            end
        end
    end
endmodule

// File: tb/tb_fat32_dir_scanner.sv
// Scoreboard bench for fat32_dir_scanner: an entry-level reference model predicts
// each found / end / sector_done event; a negedge monitor pops and compares.
module tb_fat32_dir_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] filename = '0;
    logic [23:0] extension = '0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        block_done = 1'b0;
    logic        busy, found, end_of_dir, sector_done;
    logic [31:0] first_cluster, file_size;
    logic [3:0]  entry_slot;

    fat32_dir_scanner dut (
        .clk(clk), .rst(rst), .filename(filename), .extension(extension),
        .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .block_done(block_done), .busy(busy), .found(found),
        .end_of_dir(end_of_dir), .sector_done(sector_done),
        .first_cluster(first_cluster), .file_size(file_size),
        .entry_slot(entry_slot)
    );

    always #5 clk = ~clk;

    // kind: 0 found, 1 end of directory, 2 sector done
    typedef struct {
        int          kind;
        int          pos;
        logic [31:0] cl;
        logic [31:0] sz;
        logic [3:0]  slot;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          bytes_sent = 0;
    int          model_base = 0;
    logic [7:0]  sec [512];
    logic [87:0] tgt;
    logic        found_p = 1'b0, eod_p = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [87:0] rand_name();
        logic [87:0] n;
        for (int k = 0; k < 11; k++)
            n[87-8*k -: 8] = (k > 0 && $urandom_range(4) == 0) ? 8'h20
                                                                : 8'h41 + 8'($urandom_range(25));
        return n;
    endfunction

    task automatic set_entry(input int slot, input logic [87:0] name, input logic [7:0] attr);
        for (int k = 0; k < 32; k++) sec[slot*32+k] = 8'($urandom);
        for (int k = 0; k < 11; k++) sec[slot*32+k] = name[87-8*k -: 8];
        sec[slot*32+11] = attr;
    endtask

    task automatic fill_junk();
        for (int s = 0; s < 16; s++) set_entry(s, rand_name(), 8'h20);
    endtask

    // Reference: walk whole entries in order; first end marker or qualifying name decides
    task automatic model_sector(input int len, input bit bd, inout bit term);
        int b;
        bit ok;
        logic [31:0] cl;
        if (term) return;
        for (int e = 0; e * 32 < len; e++) begin
            b = e * 32;
            if (sec[b] == 8'h00) begin
                exp_q.push_back(ev_t'{kind: 1, pos: model_base + b + 1, cl: 0, sz: 0, slot: e[3:0]});
                term = 1;
                return;
            end
            if (b + 32 > len) break;
            ok = (sec[b] != 8'hE5);
            for (int k = 0; k < 11; k++)
                if (sec[b+k] != tgt[87-8*k -: 8]) ok = 0;
            if (sec[b+11] == 8'h0F || sec[b+11][3] || sec[b+11][4]) ok = 0;
            if (ok) begin
                cl = {sec[b+21], sec[b+20], sec[b+27], sec[b+26]} & 32'h0FFF_FFFF;
                exp_q.push_back(ev_t'{kind: 0, pos: model_base + b + 32, cl: cl,
                                      sz: {sec[b+31], sec[b+30], sec[b+29], sec[b+28]},
                                      slot: e[3:0]});
                term = 1;
                return;
            end
        end
        if (bd) exp_q.push_back(ev_t'{kind: 2, pos: model_base + len, cl: 0, sz: 0, slot: 0});
        model_base += len;
    endtask

    task automatic drive_sector(input int len, input bit bd, input bit simul, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            byte_valid = 1'b1;
            byte_in    = sec[i];
            if (bd && simul && i == len - 1) block_done = 1'b1;
            @(posedge clk);
            bytes_sent++;
            #1;
            byte_valid = 1'b0;
            block_done = 1'b0;
            if ($urandom_range(99) < gap_pct) tick();
        end
        if (bd && !simul) begin
            block_done = 1'b1;
            tick();
            block_done = 1'b0;
        end
    endtask

    task automatic do_start(input logic [87:0] t);
        tgt       = t;
        filename  = t[87:24];
        extension = t[23:0];
        start     = 1'b1;
        tick();
        start      = 1'b0;
        filename   = {$urandom, $urandom};
        extension  = 24'($urandom);
        bytes_sent = 0;
        model_base = 0;
    endtask

    task automatic finish_scan(input string nm);
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_events actual=%0d required=0", nm, exp_q.size());
        end
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  k;
        k = -1;
        if (found && !found_p) k = 0;
        else if (end_of_dir && !eod_p) k = 1;
        else if (sector_done) k = 2;
        found_p <= found;
        eod_p   <= end_of_dir;
        if (k >= 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual kind=%0d pos=%0d required none", k, bytes_sent);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || bytes_sent != e.pos || busy != (k == 2) ||
                    (k != 0 && found) ||
                    (k == 0 && (first_cluster != e.cl || file_size != e.sz || entry_slot != e.slot))) begin
                    errors++;
                    $display("FAIL event actual kind=%0d pos=%0d busy=%0d cl=%h sz=%h slot=%0d required kind=%0d pos=%0d cl=%h sz=%h slot=%0d",
                             k, bytes_sent, busy, first_cluster, file_size, entry_slot,
                             e.kind, e.pos, e.cl, e.sz, e.slot);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          term;
        logic [87:0] rd;
        int          len;
        rd = "README  TXT";

        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_found", {31'd0, found}, 0);
        chk("reset_eod", {31'd0, end_of_dir}, 0);
        chk("reset_cluster", first_cluster, 0);
        repeat (2) tick();
        rst = 1'b0;
        block_done = 1'b1;
        tick();
        block_done = 1'b0;
        tick();
        chk("idle_block_done_busy", {31'd0, busy}, 0);

        // README.TXT at slot 2
        do_start(rd);
        term = 0;
        fill_junk();
        set_entry(2, rd, 8'h20);
        sec[84] = 8'h12; sec[85] = 8'h00; sec[90] = 8'h34; sec[91] = 8'h56;
        sec[92] = 8'h00; sec[93] = 8'h10; sec[94] = 8'h00; sec[95] = 8'h00;
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        finish_scan("readme");
        chk("readme_found", {31'd0, found}, 1);
        chk("readme_busy", {31'd0, busy}, 0);
        chk("readme_cluster", first_cluster, 32'h0012_5634);
        chk("readme_size", file_size, 32'h0000_1000);
        chk("readme_slot", {28'd0, entry_slot}, 2);

        // Deleted match at slot 0, live at slot 1
        do_start(rd);
        term = 0;
        fill_junk();
        set_entry(0, rd, 8'h20); sec[0] = 8'hE5;
        set_entry(1, rd, 8'h20);
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 20);
        finish_scan("deleted");
        chk("deleted_slot", {28'd0, entry_slot}, 1);

        // LFN, directory, then plain file
        do_start(rd);
        term = 0;
        fill_junk();
        set_entry(0, rd, 8'h0F);
        set_entry(1, rd, 8'h10);
        set_entry(3, rd, 8'h20);
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        finish_scan("attr");
        chk("attr_slot", {28'd0, entry_slot}, 3);

        // End marker at slot 4; later bytes and sectors ignored
        do_start(rd);
        term = 0;
        fill_junk();
        sec[128] = 8'h00;
        set_entry(6, rd, 8'h20);
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        fill_junk();
        set_entry(0, rd, 8'h20);
        drive_sector(512, 1, 0, 0);
        finish_scan("end");
        chk("end_eod", {31'd0, end_of_dir}, 1);
        chk("end_found", {31'd0, found}, 0);
        chk("end_busy", {31'd0, busy}, 0);

        // Full non-matching sector then match at slot 0 of the next
        do_start(rd);
        term = 0;
        fill_junk();
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        fill_junk();
        set_entry(0, rd, 8'h01);
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        finish_scan("next_sector");
        chk("next_sector_slot", {28'd0, entry_slot}, 0);

        // Reset in the middle of a scan
        do_start(rd);
        term = 0;
        fill_junk();
        model_sector(200, 0, term);
        drive_sector(200, 0, 0, 0);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_found", {31'd0, found}, 0);
        chk("rst_sector_done", {31'd0, sector_done}, 0);
        tick();
        rst = 1'b0;
        tick();
        do_start(rd);
        term = 0;
        fill_junk();
        set_entry(5, rd, 8'h20);
        model_sector(512, 1, term);
        drive_sector(512, 1, 0, 0);
        finish_scan("after_rst");
        chk("after_rst_slot", {28'd0, entry_slot}, 5);

        // Random scans: short sectors, gaps, block_done on the last byte
        for (int scan = 0; scan < 20; scan++) begin
            do_start(rand_name());
            term = 0;
            for (int s = 0; s < 1 + $urandom_range(2); s++) begin
                for (int e = 0; e < 16; e++) begin
                    int r;
                    r = $urandom_range(99);
                    if (r < 3) begin
                        set_entry(e, rand_name(), 8'h20);
                        sec[e*32] = 8'h00;
                    end else if (r < 9) begin
                        case ($urandom_range(3))
                            0: set_entry(e, tgt, 8'h00);
                            1: set_entry(e, tgt, 8'h01);
                            2: set_entry(e, tgt, 8'h21);
                            default: set_entry(e, tgt, 8'h04);
                        endcase
                    end else if (r < 14) begin
                        case ($urandom_range(3))
                            0: set_entry(e, tgt, 8'h0F);
                            1: set_entry(e, tgt, 8'h10);
                            2: set_entry(e, tgt, 8'h08);
                            default: set_entry(e, tgt, 8'h30);
                        endcase
                    end else if (r < 18) begin
                        set_entry(e, tgt, 8'h20);
                        sec[e*32] = 8'hE5;
                    end else begin
                        set_entry(e, rand_name(), 8'h20);
                    end
                end
                len = ($urandom_range(7) == 0) ? $urandom_range(1, 511) : 512;
                model_sector(len, 1, term);
                drive_sector(len, 1, $urandom_range(3) == 0, $urandom_range(30));
            end
            finish_scan("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fat32_dir_scanner.md
# fat32_dir_scanner

Streaming FAT32 directory-entry matcher sitting directly downstream of the SD card controller's byte stream. It is used during the FAT32 controller's root-directory phase. It consumes sector bytes as they arrive, splits them into 32-byte directory entries and compares each live entry against a target 8.3 name. It reports the matching file's first cluster and size, or reports end-of-directory or need-next-sector. It holds no sector buffer; all decisions are made on the fly.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- filename  in  64  target name, space-padded; [63:56] is the first character
- extension  in  24  target extension, space-padded; [23:16] is the first character
- start  in  1  one-cycle pulse: begin a new directory scan (clears all results)
- byte_in  in  8  sector data byte
- byte_valid  in  1  one-cycle strobe; byte_in valid this cycle
- block_done  in  1  one-cycle strobe; current 512-byte sector complete
- busy  out  1  high in SCAN
- found  out  1  level; matching entry located
- end_of_dir  out  1  level; 0x00 end marker reached with no match
- sector_done  out  1  one-cycle pulse; sector exhausted without match/end, next sector needed
- first_cluster  out  32  {cluster_hi, cluster_lo} of the match, bits [31:28] forced 0
- file_size  out  32  size in bytes of the match
- entry_slot  out  4  entry index (0-15) of the match within its sector

## Operation
- States: IDLE, SCAN, FOUND, END. Reset → IDLE; all outputs 0, byte counter 0.
- start (any state) → SCAN; clears found, end_of_dir, first_cluster, file_size, entry_slot and byte counter; latches filename/extension into internal registers.
- SCAN, per byte_valid: 9-bit byte counter `cnt`; entry offset = `cnt[4:0]`, slot = `cnt[8:5]`; counter increments and wraps 511→0.
- Entry offset 0:
  - byte 0x00 → END, end_of_dir=1, busy=0.
  - byte 0xE5 → entry marked deleted; it cannot match.
  - Otherwise it is compared as name byte 0.
- Offsets 0-7 are compared against filename bytes and offsets 8-10 against extension bytes. Any mismatch clears the per-entry match flag, which is set at offset 0.
- Offset 11 (attr): the entry cannot match if attr == 0x0F (LFN), attr[3] (volume label) or attr[4] (subdirectory).
- Offsets 20-21 capture cluster_hi, 26-27 capture cluster_lo, 28-31 capture the size; all little-endian, into shadow registers.
- At offset 31 with the match flag still set: copy shadows to first_cluster/file_size, set entry_slot=slot, enter FOUND, found=1.
- block_done in SCAN: counter → 0 and sector_done pulses for one cycle. Remaining in SCAN; the upstream controller fetches the next sector.
- FOUND/END: byte_valid and block_done are ignored; outputs hold until start or rst.
- block_done in IDLE is ignored; no sector_done.

## Timing
- Outputs are registered. found/end_of_dir/busy change on the clk edge that samples the deciding byte_valid, so they are visible the following cycle.
- sector_done is high exactly one cycle, on the edge after block_done is sampled.
- Simultaneous byte_valid and block_done: the byte is processed first (it may produce found or end, in which case no sector_done). Otherwise the counter ends at 0 and sector_done pulses.
- Simultaneous start and byte_valid/block_done: start wins; the byte is dropped.
- Back-to-back byte_valid on consecutive cycles must be accepted (one byte per cycle max).
- rst mid-scan: immediate return to IDLE with all outputs 0; the partial entry is discarded.
- A short sector (block_done before 512 bytes) still resets the counter. The partial entry is abandoned and never matches.

## Test plan
- Target "README  TXT". The sector holds an unrelated file at slot 0 and a matching entry at slot 2 with cluster bytes 20-21=0x12,0x00, 26-27=0x34,0x56, size 0x00,0x10,0x00,0x00. Required: found=1 after byte 95, first_cluster=0x00125634, file_size=0x00001000, entry_slot=2, busy=0.
- Slot 0 holds a matching name but byte 0=0xE5; slot 1 holds the live match. Required: found with entry_slot=1.
- Matching name with attr 0x0F at slot 0, 0x10 at slot 1, 0x20 at slot 3. Required: match only at slot 3.
- No match, slot 4 byte 0=0x00. Required: end_of_dir=1 after byte 128, found=0, and further bytes ignored.
- Full sector of non-matching entries then block_done. Required: one-cycle sector_done, busy stays 1. The match in the next sector at slot 0 gives entry_slot=0.
- rst asserted at byte 200 of a scan. Required: all outputs 0 immediately; after start a fresh sector matches correctly from byte 0.
